// File: rtl/llr_pack_pkg.sv
// Shared decoder package: LLR packing geometry and packer FSM encoding.
// Holds the default lane count, LLR width and frame-length width used by
// llr_pack and llr_to_sm, plus the packer state type.
package llr_pack_pkg;

  localparam int LANES = 8;   // LLR lanes per packed output word
  localparam int LLR_W = 7;   // two's-complement LLR width (lane is LLR_W+1)
  localparam int LEN_W = 10;  // frame-length counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of one packed sign-magnitude lane.
  function automatic int lane_w(input int llr_w);
    return llr_w + 1;
  endfunction

endpackage

// File: rtl/llr_to_sm.sv
// Two's-complement LLR to sign-magnitude lane converter.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of the input.
// Ports: llr  - two's-complement LLR in
//        sm   - {sign, |llr|}; the most negative code maps to sign 1, magnitude 2^(LLR_W-1)
module llr_to_sm #(
  parameter int LLR_W = llr_pack_pkg::LLR_W
) (
  input  logic [LLR_W-1:0] llr,
  output logic [LLR_W:0]   sm
);

  logic             sign;
  logic [LLR_W-1:0] mag;

  assign sign = llr[LLR_W-1];
  // Negating the most negative code wraps back to itself, which read as
  // unsigned is exactly its magnitude, so no saturation is needed.
  assign mag  = sign ? ((~llr) + LLR_W'(1)) : llr;
  assign sm   = {sign, mag};

endmodule

// File: rtl/llr_pack.sv
// Packs a frame of two's-complement LLRs into LANES-wide sign-magnitude words.
// Latency: a completed word is on o_data one cycle after its last LLR is accepted.
// Backpressure: one held word absorbs a stalled output; o_ready drops while it is occupied.
// Ports: i_clk/i_rst_n      - clock, async active-low reset
//        i_start/i_len      - frame start strobe and length (LLRs), taken in IDLE only
//        i_valid/i_llr/o_ready - input LLR handshake
//        o_valid/o_data/o_last/i_ready - output word handshake, o_last on final word
//        o_busy             - frame in progress (not IDLE)
module llr_pack #(
  parameter int LANES = llr_pack_pkg::LANES,
  parameter int LLR_W = llr_pack_pkg::LLR_W,
  parameter int LEN_W = llr_pack_pkg::LEN_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [LEN_W-1:0]             i_len,
  input  logic                         i_valid,
  input  logic [LLR_W-1:0]             i_llr,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [LANES*(LLR_W+1)-1:0]   o_data,
  output logic                         o_last,
  input  logic                         i_ready,
  output logic                         o_busy
);

  import llr_pack_pkg::*;

  localparam int LW  = LLR_W + 1;
  localparam int DW  = LANES * LW;
  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] llr_cnt;
  logic [LCW-1:0]   lane_cnt;
  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    acc_nxt;
  logic             pend;
  logic             pend_last;
  logic [LW-1:0]    sm;

  logic accept;
  logic last_llr;
  logic word_done;
  logic out_take;
  logic out_free;

  llr_to_sm #(
    .LLR_W (LLR_W)
  ) u_llr_to_sm (
    .llr (i_llr),
    .sm  (sm)
  );

  // The held word lives in acc_q, so input must stop until it moves out.
  assign o_ready   = (state == ST_FILL) && !pend;
  assign accept    = i_valid && o_ready;
  assign last_llr  = (llr_cnt + LEN_W'(1)) == len_q;
  assign word_done = accept && (last_llr || (lane_cnt == LCW'(LANES - 1)));
  assign out_take  = o_valid && i_ready;
  assign out_free  = !o_valid || i_ready;

  // Drop the converted LLR into its lane; untouched lanes stay zero because
  // acc_q is cleared whenever a word leaves it.
  always_comb begin
    acc_nxt = acc_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == LCW'(k)) begin
        acc_nxt[k*LW +: LW] = sm;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
      len_q     <= '0;
      llr_cnt   <= '0;
      lane_cnt  <= '0;
      acc_q     <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      // Output register and held-word handling. accept is never true while
      // pend is set, so a completing word and a held-word reload are exclusive.
      if (word_done) begin
        if (out_free) begin
          o_data  <= acc_nxt;
          o_last  <= last_llr;
          o_valid <= 1'b1;
          acc_q   <= '0;
        end else begin
          acc_q     <= acc_nxt;
          pend      <= 1'b1;
          pend_last <= last_llr;
        end
      end else begin
        if (accept) begin
          acc_q <= acc_nxt;
        end
        if (pend && out_take) begin
          o_data  <= acc_q;
          o_last  <= pend_last;
          o_valid <= 1'b1;
          acc_q   <= '0;
          pend    <= 1'b0;
        end else if (out_take) begin
          o_valid <= 1'b0;
        end
      end

      if (accept) begin
        llr_cnt  <= llr_cnt + LEN_W'(1);
        lane_cnt <= word_done ? '0 : lane_cnt + LCW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (i_start && (i_len != '0)) begin
            state    <= ST_FILL;
            o_busy   <= 1'b1;
            len_q    <= i_len;
            llr_cnt  <= '0;
            lane_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (accept && last_llr) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Only the frame's final word carries o_last, so its acceptance
          // means nothing is left in the output register or held.
          if (out_take && o_last) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
